// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
//  Package     : mips_defs
//  Description : Opcode/funct encodings, Tuse/Tnew timing constants and
//                instruction classification helpers shared by the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;

  // SPECIAL funct codes (instr[5:0])
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_JR      = 6'h08;

  // Tuse: cycles from D until the operand is consumed. TUSE_NONE marks an
  // operand the instruction does not read; it is never below any Tnew.
  localparam logic [1:0] TUSE_0     = 2'd0;
  localparam logic [1:0] TUSE_1     = 2'd1;
  localparam logic [1:0] TUSE_2     = 2'd2;
  localparam logic [1:0] TUSE_NONE  = 2'd3;

  // Tnew: cycles until a result is available for forwarding.
  localparam logic [1:0] TNEW_0      = 2'd0;
  localparam logic [1:0] TNEW_1      = 2'd1;
  localparam logic [1:0] TNEW_2      = 2'd2;
  localparam logic [1:0] TNEW_M_LOAD = 2'd1;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [3:0] {
    I_NOP  = 4'd0,
    I_ADDU = 4'd1,
    I_SUBU = 4'd2,
    I_ORI  = 4'd3,
    I_LUI  = 4'd4,
    I_LW   = 4'd5,
    I_SW   = 4'd6,
    I_BEQ  = 4'd7,
    I_J    = 4'd8,
    I_JAL  = 4'd9,
    I_JR   = 4'd10
  } instr_e;

  // Anything outside the supported set collapses to I_NOP.
  function automatic instr_e classify(input logic [5:0] op, input logic [5:0] fn);
    instr_e c;
    c = I_NOP;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_ADDU: c = I_ADDU;
          FN_SUBU: c = I_SUBU;
          FN_JR:   c = I_JR;
          default: c = I_NOP;
        endcase
      end
      OP_ORI:  c = I_ORI;
      OP_LUI:  c = I_LUI;
      OP_LW:   c = I_LW;
      OP_SW:   c = I_SW;
      OP_BEQ:  c = I_BEQ;
      OP_J:    c = I_J;
      OP_JAL:  c = I_JAL;
      default: c = I_NOP;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] tuse_rs(input instr_e c);
    case (c)
      I_BEQ, I_JR:                       return TUSE_0;
      I_ADDU, I_SUBU, I_ORI, I_LW, I_SW: return TUSE_1;
      default:                           return TUSE_NONE;
    endcase
  endfunction

  function automatic logic [1:0] tuse_rt(input instr_e c);
    case (c)
      I_BEQ:          return TUSE_0;
      I_ADDU, I_SUBU: return TUSE_1;
      I_SW:           return TUSE_2;
      default:        return TUSE_NONE;
    endcase
  endfunction

  // Tnew of an instruction sitting in E.
  function automatic logic [1:0] tnew_e(input instr_e c);
    case (c)
      I_LW:                         return TNEW_2;
      I_ADDU, I_SUBU, I_ORI, I_LUI: return TNEW_1;
      default:                      return TNEW_0;
    endcase
  endfunction

endpackage : mips_defs
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Combinational stall decision from the D operands' Tuse and
//                the pending writers in E and M.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
  import mips_defs::*;
(
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] e_wa,
  input  logic [1:0] e_tnew,
  input  logic [4:0] m_wa,
  input  logic       m_is_load,
  output logic       stall
);

  // One operand stalls when a producer cannot deliver it before it is needed.
  function automatic logic operand_blocked(
    input logic [4:0] r,
    input logic [1:0] tuse,
    input logic [4:0] ewa,
    input logic [1:0] etnew,
    input logic [4:0] mwa,
    input logic       mload
  );
    logic blk;
    blk = 1'b0;
    if (r != 5'd0 && tuse != TUSE_NONE) begin
      if (r == ewa && tuse < etnew)
        blk = 1'b1;
      if (r == mwa && mload && tuse < TNEW_M_LOAD)
        blk = 1'b1;
    end
    return blk;
  endfunction

  logic rs_blocked;
  logic rt_blocked;

  // Evaluate both source operands against the E and M writers.
  always_comb begin
    rs_blocked = operand_blocked(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_is_load);
    rt_blocked = operand_blocked(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_is_load);
  end

  assign stall = rs_blocked | rt_blocked;

endmodule : hazard_unit
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : MIPS decode stage. Decodes the F/D word, resolves
//                beq/j/jal/jr, drives next-PC and stall back to fetch and
//                loads the D/E pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_instruc,
  input  logic [31:0] FD_PC,
  input  logic [31:0] F_N_PC,
  input  logic [31:0] D_rs_data,
  input  logic [31:0] D_rt_data,
  input  logic [4:0]  M_wa,
  input  logic        M_is_load,
  output logic [4:0]  D_rs_addr,
  output logic [4:0]  D_rt_addr,
  output logic [31:0] F_NPC,
  output logic        stall,
  output logic [31:0] DE_instruc,
  output logic [31:0] DE_PC,
  output logic [31:0] DE_rs_data,
  output logic [31:0] DE_rt_data,
  output logic [31:0] DE_imm32,
  output logic [4:0]  DE_wa,
  output logic        DE_is_load
);

  instr_e      d_cls;
  instr_e      e_cls;
  logic [31:0] d_imm32;
  logic [4:0]  d_wa;
  logic [31:0] pc_plus4;
  logic [31:0] npc;
  logic [1:0]  e_tnew;

  logic [31:0] de_instruc_q, de_instruc_d;
  logic [31:0] de_pc_q,      de_pc_d;
  logic [31:0] de_rs_data_q, de_rs_data_d;
  logic [31:0] de_rt_data_q, de_rt_data_d;
  logic [31:0] de_imm32_q,   de_imm32_d;
  logic [4:0]  de_wa_q,      de_wa_d;
  logic        de_is_load_q, de_is_load_d;

  assign D_rs_addr = F_instruc[25:21];
  assign D_rt_addr = F_instruc[20:16];

  // Classify the D instruction and derive its immediate and destination.
  always_comb begin
    d_cls   = classify(F_instruc[31:26], F_instruc[5:0]);
    d_imm32 = 32'd0;
    d_wa    = 5'd0;
    case (d_cls)
      I_ORI:               d_imm32 = {16'd0, F_instruc[15:0]};
      I_LUI:               d_imm32 = {F_instruc[15:0], 16'd0};
      I_LW, I_SW, I_BEQ:   d_imm32 = {{16{F_instruc[15]}}, F_instruc[15:0]};
      default:             d_imm32 = 32'd0;
    endcase
    case (d_cls)
      I_ADDU, I_SUBU:      d_wa = F_instruc[15:11];
      I_ORI, I_LUI, I_LW:  d_wa = F_instruc[20:16];
      I_JAL:               d_wa = 5'd31;
      default:             d_wa = 5'd0;
    endcase
  end

  // Next-PC selection; control transfers are relative to the delay slot.
  always_comb begin
    pc_plus4 = FD_PC + 32'd4;
    npc      = F_N_PC + 32'd4;
    case (d_cls)
      I_BEQ: if (D_rs_data == D_rt_data) npc = pc_plus4 + {d_imm32[29:0], 2'b00};
      I_J,
      I_JAL: npc = {pc_plus4[31:28], F_instruc[25:0], 2'b00};
      I_JR:  npc = D_rs_data;
      default: npc = F_N_PC + 32'd4;
    endcase
  end

  assign F_NPC = npc;

  // Result latency of whatever currently sits in E.
  always_comb begin
    e_cls  = classify(de_instruc_q[31:26], de_instruc_q[5:0]);
    e_tnew = de_is_load_q ? TNEW_2 : tnew_e(e_cls);
  end

  hazard_unit u_hazard_unit (
    .d_rs      (F_instruc[25:21]),
    .d_rt      (F_instruc[20:16]),
    .d_tuse_rs (tuse_rs(d_cls)),
    .d_tuse_rt (tuse_rt(d_cls)),
    .e_wa      (de_wa_q),
    .e_tnew    (e_tnew),
    .m_wa      (M_wa),
    .m_is_load (M_is_load),
    .stall     (stall)
  );

  // Next D/E contents: a bubble while stalled, otherwise the decoded fields.
  always_comb begin
    de_pc_d      = FD_PC;
    de_instruc_d = 32'd0;
    de_rs_data_d = 32'd0;
    de_rt_data_d = 32'd0;
    de_imm32_d   = 32'd0;
    de_wa_d      = 5'd0;
    de_is_load_d = 1'b0;
    if (!stall) begin
      de_instruc_d = F_instruc;
      de_rs_data_d = D_rs_data;
      de_rt_data_d = D_rt_data;
      de_imm32_d   = d_imm32;
      de_wa_d      = d_wa;
      de_is_load_d = (d_cls == I_LW);
    end
  end

  // D/E pipeline register; reset leaves a bubble in E at the reset PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de_instruc_q <= 32'd0;
      de_pc_q      <= RESET_PC;
      de_rs_data_q <= 32'd0;
      de_rt_data_q <= 32'd0;
      de_imm32_q   <= 32'd0;
      de_wa_q      <= 5'd0;
      de_is_load_q <= 1'b0;
    end else begin
      de_instruc_q <= de_instruc_d;
      de_pc_q      <= de_pc_d;
      de_rs_data_q <= de_rs_data_d;
      de_rt_data_q <= de_rt_data_d;
      de_imm32_q   <= de_imm32_d;
      de_wa_q      <= de_wa_d;
      de_is_load_q <= de_is_load_d;
    end
  end

  assign DE_instruc = de_instruc_q;
  assign DE_PC      = de_pc_q;
  assign DE_rs_data = de_rs_data_q;
  assign DE_rt_data = de_rt_data_q;
  assign DE_imm32   = de_imm32_q;
  assign DE_wa      = de_wa_q;
  assign DE_is_load = de_is_load_q;

endmodule : id_stage
`default_nettype wire
